// File: rtl/lfsr_pkg.sv
// Shared definitions for the serial LFSR CRC generator/checker pair.
package lfsr_pkg;

    localparam int unsigned LFSR_WIDTH = 8;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'b0100_0100;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = '0;

    // Widest LFSR the shared step function supports; callers zero-extend.
    localparam int unsigned LFSR_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CHECK
    } state_t;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] lfsr,
        input logic                  din,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width
    );
        logic                  fb;
        logic [LFSR_MAX_W-1:0] nxt;
        fb  = din ^ lfsr[0];
        nxt = '0;
        for (int unsigned i = 0; i < LFSR_MAX_W; i++) begin
            if (i + 1 < width) begin
                nxt[i] = lfsr[i+1] ^ (taps[i] & fb);
            end else if (i + 1 == width) begin
                nxt[i] = fb;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_crc_checker_if.sv
// Serial link between the CRC generator and the checker, plus verdict lines.
interface lfsr_crc_checker_if;

    logic ACTIVE;
    logic DATA;
    logic CRC;
    logic CRC_VALID;
    logic BUSY;
    logic DONE;
    logic CRC_OK;
    logic PROTO_ERR;

    modport master (
        output ACTIVE, DATA, CRC, CRC_VALID,
        input  BUSY, DONE, CRC_OK, PROTO_ERR
    );

    modport slave (
        input  ACTIVE, DATA, CRC, CRC_VALID,
        output BUSY, DONE, CRC_OK, PROTO_ERR
    );

endinterface

// File: rtl/crc_lfsr_core.sv
// LFSR register with load-seed / absorb / shift-out controls.
module crc_lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED
) (
    input  logic clk,
    input  logic rst,
    input  logic load_seed,
    input  logic absorb,
    input  logic shift_out,
    input  logic din,
    output logic lsb
);

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] base;

    // Absorbing together with load_seed starts a fresh frame from SEED.
    always_comb begin
        base = load_seed ? SEED : lfsr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (absorb) begin
            lfsr <= WIDTH'(lfsr_next(LFSR_MAX_W'(base), din, LFSR_MAX_W'(TAPS), WIDTH));
        end else if (load_seed) begin
            lfsr <= SEED;
        end else if (shift_out) begin
            lfsr <= {1'b0, lfsr[WIDTH-1:1]};
        end
    end

    assign lsb = lfsr[0];

endmodule

// File: rtl/lfsr_crc_checker.sv
// Receive-side serial CRC checker: absorbs DATA, compares received CRC bits,
// and issues a one-cycle verdict per frame.
module lfsr_crc_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED
) (
    input logic               clk,
    input logic               rst,
    lfsr_crc_checker_if.slave bus
);

    localparam int unsigned     CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          err, err_n;
    logic          busy, busy_n;
    logic          done, done_n;
    logic          crc_ok, crc_ok_n;
    logic          proto_err, proto_err_n;
    logic          load_seed, absorb, shift_out;
    logic          lsb, mismatch;

    crc_lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load_seed (load_seed),
        .absorb    (absorb),
        .shift_out (shift_out),
        .din       (bus.DATA),
        .lsb       (lsb)
    );

    assign mismatch = bus.CRC ^ lsb;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        err_n       = err;
        done_n      = 1'b0;
        crc_ok_n    = crc_ok;
        proto_err_n = proto_err;
        load_seed   = 1'b0;
        absorb      = 1'b0;
        shift_out   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                load_seed = 1'b1;
                err_n     = 1'b0;
                cnt_n     = '0;
                if (bus.ACTIVE) begin
                    absorb  = 1'b1;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.ACTIVE) begin
                    absorb = 1'b1;
                end else if (bus.CRC_VALID) begin
                    shift_out = 1'b1;
                    err_n     = mismatch;
                    cnt_n     = CW'(1);
                    state_n   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bus.ACTIVE) begin
                    done_n      = 1'b1;
                    crc_ok_n    = 1'b0;
                    proto_err_n = 1'b1;
                    load_seed   = 1'b1;
                    state_n     = ST_IDLE;
                end else if (bus.CRC_VALID) begin
                    if (cnt == LAST) begin
                        done_n      = 1'b1;
                        crc_ok_n    = ~(err | mismatch);
                        proto_err_n = 1'b0;
                        load_seed   = 1'b1;
                        state_n     = ST_IDLE;
                    end else begin
                        shift_out = 1'b1;
                        err_n     = err | mismatch;
                        cnt_n     = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            err       <= err_n;
            busy      <= busy_n;
            done      <= done_n;
            crc_ok    <= crc_ok_n;
            proto_err <= proto_err_n;
        end
    end

    assign bus.BUSY      = busy;
    assign bus.DONE      = done;
    assign bus.CRC_OK    = crc_ok;
    assign bus.PROTO_ERR = proto_err;

endmodule

// File: tb/tb_lfsr_crc_checker.sv
// Directed bench for lfsr_crc_checker with a verdict scoreboard.
module tb_lfsr_crc_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lfsr_crc_checker_if bus ();

    lfsr_crc_checker #(
        .WIDTH (8),
        .TAPS  (8'b0100_0100),
        .SEED  (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {1, TAPS[6:0]}: bit 7 takes the feedback directly.
    localparam logic [7:0] FB_MASK = 8'b1100_0100;

    typedef struct packed {
        logic ok;
        logic pe;
    } verdict_t;

    verdict_t exp_q[$];
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;
    int n_push = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_crc(input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            fb = d[i] ^ r[0];
            r  = (r >> 1) ^ (fb ? FB_MASK : 8'h00);
        end
        return r;
    endfunction

    task automatic expect_verdict(input logic ok, input logic pe);
        verdict_t v;
        v.ok = ok;
        v.pe = pe;
        exp_q.push_back(v);
        n_push++;
    endtask

    task automatic step(input logic a, input logic d, input logic v, input logic c);
        bus.ACTIVE    = a;
        bus.DATA      = d;
        bus.CRC_VALID = v;
        bus.CRC       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
        end
    endtask

    task automatic send_data(input logic [7:0] d, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            step(1'b1, d[i], 1'($urandom_range(1)), 1'($urandom_range(1)));
            if (i == 0) check1("busy_rise", bus.BUSY, 1'b1);
            if (i < nbits - 1) idle(gap);
        end
    endtask

    task automatic send_crc(input logic [7:0] c, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            if (i == 7) check1("done_not_early", bus.DONE, 1'b0);
            step(1'b0, 1'($urandom_range(1)), 1'b1, c[i]);
            if (i < nbits - 1) idle(gap);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] c, input int gap);
        send_data(d, 8, gap);
        idle(gap);
        send_crc(c, 8, gap);
    endtask

    // Scoreboard: every DONE pulse pops one expected verdict.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus.DONE === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check1("done_unexpected", bus.DONE, 1'b0);
                end else begin
                    verdict_t e;
                    e = exp_q.pop_front();
                    check1("verdict_crc_ok", bus.CRC_OK, e.ok);
                    check1("verdict_proto_err", bus.PROTO_ERR, e.pe);
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic [7:0] c;
        int         d0;

        bus.ACTIVE    = 1'b0;
        bus.DATA      = 1'b0;
        bus.CRC       = 1'b0;
        bus.CRC_VALID = 1'b0;

        // Reset state
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check1("rst_busy", bus.BUSY, 1'b0);
        check1("rst_done", bus.DONE, 1'b0);
        check1("rst_crc_ok", bus.CRC_OK, 1'b0);
        check1("rst_proto_err", bus.PROTO_ERR, 1'b0);
        rst = 1'b0;

        // CRC_VALID alone in IDLE is ignored
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check1("idle_crc_ignored_busy", bus.BUSY, 1'b0);
        check1("idle_crc_ignored_done", bus.DONE, 1'b0);

        // Good frame: DATA 1,1,0,0,0,0,1,1 -> CRC 0,1,0,0,1,0,1,1 (0xD2 LSB first)
        expect_verdict(1'b1, 1'b0);
        send_frame(8'hC3, 8'hD2, 0);
        check1("good_done", bus.DONE, 1'b1);
        check1("good_crc_ok", bus.CRC_OK, 1'b1);
        check1("good_busy_fall", bus.BUSY, 1'b0);
        idle(1);
        check1("good_done_one_cycle", bus.DONE, 1'b0);
        check1("good_crc_ok_held", bus.CRC_OK, 1'b1);

        // Bad CRC: bit 4 flipped to 0; verdict only after all 8 bits
        expect_verdict(1'b0, 1'b0);
        send_frame(8'hC3, 8'hC2, 0);
        check1("bad_done", bus.DONE, 1'b1);
        check1("bad_crc_ok", bus.CRC_OK, 1'b0);
        check1("bad_proto_err", bus.PROTO_ERR, 1'b0);
        idle(2);

        // Gaps everywhere; DONE still exactly one cycle after the 8th CRC bit
        expect_verdict(1'b1, 1'b0);
        send_frame(8'hC3, 8'hD2, 2);
        check1("gap_done", bus.DONE, 1'b1);
        check1("gap_crc_ok", bus.CRC_OK, 1'b1);
        idle(1);

        // Random payloads against the reference model, good and corrupted
        for (int n = 0; n < 4; n++) begin
            d = 8'($urandom);
            c = ref_crc(d);
            if (n[0]) begin
                c = c ^ (8'h01 << $urandom_range(7));
                expect_verdict(1'b0, 1'b0);
            end else begin
                expect_verdict(1'b1, 1'b0);
            end
            send_frame(d, c, n);
            check1("rand_done", bus.DONE, 1'b1);
            check1("rand_crc_ok", bus.CRC_OK, ~n[0]);
            idle(1);
        end

        // Abort: ACTIVE after 3 CRC bits
        expect_verdict(1'b0, 1'b1);
        send_data(8'hC3, 8, 0);
        send_crc(8'hD2, 3, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check1("abort_done", bus.DONE, 1'b1);
        check1("abort_busy", bus.BUSY, 1'b0);
        check1("abort_proto_err", bus.PROTO_ERR, 1'b1);
        check1("abort_crc_ok", bus.CRC_OK, 1'b0);
        idle(1);
        check1("abort_bit_dropped", bus.BUSY, 1'b0);
        check1("abort_proto_err_held", bus.PROTO_ERR, 1'b1);

        // Back-to-back: second frame's first DATA bit lands in the DONE cycle
        expect_verdict(1'b1, 1'b0);
        expect_verdict(1'b1, 1'b0);
        send_frame(8'hC3, 8'hD2, 0);
        check1("b2b_first_done", bus.DONE, 1'b1);
        send_frame(8'hC3, 8'hD2, 0);
        check1("b2b_second_done", bus.DONE, 1'b1);
        check1("b2b_second_crc_ok", bus.CRC_OK, 1'b1);
        check1("b2b_second_proto_err", bus.PROTO_ERR, 1'b0);
        idle(1);

        // Reset mid-frame: partial frame discarded with no verdict
        d0 = n_done;
        send_data(8'hC3, 5, 0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check1("midrst_busy", bus.BUSY, 1'b0);
        check1("midrst_done", bus.DONE, 1'b0);
        check1("midrst_crc_ok", bus.CRC_OK, 1'b0);
        check1("midrst_proto_err", bus.PROTO_ERR, 1'b0);
        idle(3);
        checkn("midrst_no_verdict", n_done, d0);
        expect_verdict(1'b1, 1'b0);
        send_frame(8'hC3, 8'hD2, 0);
        check1("post_rst_done", bus.DONE, 1'b1);
        check1("post_rst_crc_ok", bus.CRC_OK, 1'b1);

        idle(3);
        checkn("scoreboard_drained", exp_q.size(), 0);
        checkn("done_count", n_done, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        n_bad++;
        $display("FAIL timeout: simulation did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lfsr_crc_checker.md
# lfsr_crc_checker

- Receive-side counterpart of the serial LFSR CRC generator.
- Absorbs the same serial data stream with the same LFSR, then takes the generator's CRC bits in transmit order and compares them bit by bit.
- Reports a one-cycle verdict per frame: CRC pass/fail, plus a protocol-error flag for malformed framing.
- Sits at the far end of the serial link, directly fed by the generator's DATA/ACTIVE and CRC/Valid lines.

## Interface
- WIDTH, 8, LFSR/CRC length in bits
- TAPS, 8'b01000100, feedback tap mask; bit i set means stage i XORs in feedback
- SEED, 8'b00000000, LFSR value at reset and at every frame start
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ACTIVE  in  1  data phase strobe; DATA sampled when high
- DATA  in  1  serial payload bit
- CRC  in  1  serial received CRC bit
- CRC_VALID  in  1  CRC bit strobe; CRC sampled when high
- BUSY  out  1  frame in progress (state != IDLE)
- DONE  out  1  one-cycle pulse: frame verdict valid
- CRC_OK  out  1  verdict: all WIDTH CRC bits matched; held until next DONE
- PROTO_ERR  out  1  verdict: frame aborted by framing violation; held until next DONE

## Operation
- LFSR update per absorbed DATA bit:
  - fb = DATA ^ lfsr[0]
  - next[WIDTH-1] = fb
  - next[i] = lfsr[i+1] ^ (TAPS[i] & fb) for i < WIDTH-1
- Check step per sampled CRC bit:
  - mismatch if CRC != lfsr[0]; mismatch sets sticky err
  - lfsr shifts right with 0 fill; bit counter increments
- States: IDLE, DATA, CHECK.
- IDLE:
  - lfsr = SEED, err = 0, cnt = 0.
  - ACTIVE=1: absorb bit, go to DATA.
  - CRC_VALID alone is ignored.
- DATA:
  - ACTIVE=1: absorb bit; CRC_VALID is ignored in the same cycle.
  - ACTIVE=0, CRC_VALID=1: check step, cnt=1, go to CHECK.
  - Both low: stall; gaps of any length are allowed.
- CHECK:
  - CRC_VALID=1: check step.
  - If this is bit WIDTH: DONE=1, CRC_OK=~(err|mismatch), PROTO_ERR=0, lfsr=SEED, go to IDLE.
  - ACTIVE=1 (any CRC_VALID): abort. DONE=1, CRC_OK=0, PROTO_ERR=1, go to IDLE. The DATA bit is dropped.
  - Both low: stall.
- Counter width is clog2(WIDTH+1); it never wraps, because the frame ends at WIDTH.
- rst at any time: state=IDLE, lfsr=SEED, err=0, cnt=0, DONE=0, CRC_OK=0, PROTO_ERR=0. A partial frame is discarded with no verdict.

## Timing
- All outputs are registered. Reset values are 0 for BUSY, DONE, CRC_OK and PROTO_ERR.
- DONE is high exactly one cycle, starting the cycle after the edge that sampled the last CRC bit or the aborting ACTIVE.
- Back-to-back frames: ACTIVE may be high in the DONE cycle. That bit is absorbed from SEED as the first bit of the next frame, and BUSY rises again.
- BUSY rises the cycle after the first DATA sample. It falls in the same cycle DONE rises, unless a new frame starts.
- Latency from the last CRC bit to the verdict is 1 cycle.

## Structure
- Shared package lfsr_pkg, shared with the generator:
  - default WIDTH/TAPS/SEED
  - state enum (IDLE, DATA, CHECK)
  - pure function lfsr_next(lfsr, din, taps)
- One natural sub-module: crc_lfsr_core.
  - Holds the LFSR register with load-seed / absorb / shift-out controls.
  - Is reusable by the generator.
- The FSM, counter and verdict registers live in lfsr_crc_checker.

## Test plan
- Good frame: DATA 1,1,0,0,0,0,1,1 with ACTIVE → lfsr=8'b1101_0010. Then CRC 0,1,0,0,1,0,1,1 with CRC_VALID → DONE pulse, CRC_OK=1, PROTO_ERR=0.
- Bad CRC: same frame, but CRC bit 4 flipped to 0 → DONE pulse, CRC_OK=0, PROTO_ERR=0 after all 8 bits (not early).
- Gaps: the good frame with idle cycles inserted between data bits, between data and CRC, and inside the CRC bits → same verdict. DONE comes 1 cycle after the 8th CRC bit.
- Abort: ACTIVE=1 after 3 CRC bits → DONE, CRC_OK=0, PROTO_ERR=1, BUSY=0 next cycle.
- Back-to-back: second good frame starts in the DONE cycle of the first → two DONE pulses, both CRC_OK=1, second lfsr absorbs from SEED.
- Reset mid-frame: rst after 5 data bits → all outputs 0 next cycle, no DONE. A following good frame passes.
